// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch unit.
package fetch_pkg;

   typedef enum logic [2:0] {
      RESET_ST,
      REQ,
      WAIT,
      ISSUE,
      HALT,
      FAULT
   } fetch_state_e;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_RANGE    = 2'b10;
   localparam logic [1:0] FC_TIMEOUT  = 2'b11;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check of a candidate fetch address against the IMEM window.
module fetch_addr_check #(
   parameter logic [19:0] IMEM_BASE = 20'h01000,
   parameter int          IMEM_SIZE = 2048
) (
   input  logic [31:0] addr,
   output logic        misaligned,
   output logic        out_of_window
);

   localparam logic [31:0] SIZE_W = 32'(IMEM_SIZE);

   assign misaligned    = (addr[1:0] != 2'b00);
   assign out_of_window = (addr[31:12] != IMEM_BASE) || ({20'd0, addr[11:0]} >= SIZE_W);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: PC, IMEM request/response, decode handshake,
// halt-sentinel detection and sticky fault reporting.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0100_0000,
   parameter logic [19:0] IMEM_BASE = 20'h01000,
   parameter int          IMEM_SIZE = 2048,
   parameter int          TIMEOUT   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instrf_update,
   input  logic [31:0] instr,
   input  logic        advance,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        instrfetch,
   output logic [31:0] addr_imem,
   output logic [31:0] pc,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   fetch_state_e     state, state_nxt;
   logic [CNT_W-1:0] to_cnt;
   logic [31:0]      pc_next;
   logic             next_misaligned;
   logic             next_oow;
   logic             cnt_expired;
   logic             is_halt_word;

   assign pc_next      = branch_taken ? branch_target : pc + 32'd4;
   assign cnt_expired  = (to_cnt == CNT_W'(TIMEOUT - 1));
   assign is_halt_word = (instr == HALT_WORD);
   assign addr_imem    = pc;

   fetch_addr_check #(
      .IMEM_BASE (IMEM_BASE),
      .IMEM_SIZE (IMEM_SIZE)
   ) u_addr_check (
      .addr          (pc_next),
      .misaligned    (next_misaligned),
      .out_of_window (next_oow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_ST;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      instrfetch = 1'b0;
      case (state)
         RESET_ST: state_nxt = REQ;
         REQ: begin
            instrfetch = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            instrfetch = 1'b1;
            if (instrf_update) begin
               state_nxt = is_halt_word ? HALT : ISSUE;
            end else if (cnt_expired) begin
               state_nxt = FAULT;
            end
         end
         ISSUE: begin
            if (advance) begin
               state_nxt = (next_misaligned || next_oow) ? FAULT : REQ;
            end
         end
         default: state_nxt = state;
      endcase
   end

   // Datapath and sticky status; all updates keyed off the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         ir          <= 32'd0;
         ir_valid    <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= FC_NONE;
         fault_addr  <= 32'd0;
         to_cnt      <= '0;
      end else begin
         case (state)
            REQ: to_cnt <= '0;
            WAIT: begin
               if (instrf_update) begin
                  ir <= instr;
                  if (is_halt_word) begin
                     halted <= 1'b1;
                  end else begin
                     ir_valid <= 1'b1;
                  end
               end else if (cnt_expired) begin
                  fault       <= 1'b1;
                  fault_cause <= FC_TIMEOUT;
                  fault_addr  <= pc;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ISSUE: begin
               if (advance) begin
                  ir_valid <= 1'b0;
                  if (next_misaligned) begin
                     fault       <= 1'b1;
                     fault_cause <= FC_MISALIGN;
                     fault_addr  <= pc_next;
                  end else if (next_oow) begin
                     fault       <= 1'b1;
                     fault_cause <= FC_RANGE;
                     fault_addr  <= pc_next;
                  end else begin
                     pc <= pc_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency IMEM model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        instrf_update;
   logic [31:0] instr;
   logic        advance;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        instrfetch;
   logic [31:0] addr_imem;
   logic [31:0] pc;
   logic [31:0] ir;
   logic        ir_valid;
   logic        halted;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;
   logic        respond_en;

   int total = 0;
   int bad   = 0;

   fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instrf_update (instrf_update),
      .instr         (instr),
      .advance       (advance),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instrfetch    (instrfetch),
      .addr_imem     (addr_imem),
      .pc            (pc),
      .ir            (ir),
      .ir_valid      (ir_valid),
      .halted        (halted),
      .fault         (fault),
      .fault_cause   (fault_cause),
      .fault_addr    (fault_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0100_0000: return 32'h0200_0103;
         32'h0100_0004: return 32'h0050_0093;
         32'h0100_0100: return 32'h00A0_0113;
         32'h0100_07FC: return 32'hFFFF_FFFF;
         default:       return 32'h0000_0013;
      endcase
   endfunction

   // IMEM: registers the request and answers one cycle later, single-shot per request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instrf_update <= 1'b0;
         instr         <= 32'd0;
      end else begin
         instrf_update <= instrfetch && !instrf_update && respond_en;
         instr         <= mem_word(addr_imem);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_settle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ir_valid || halted || fault) begin
            ok = 1'b1;
            break;
         end
      end
      chk("settle", {31'd0, ok}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply_advance(input logic bt, input logic [31:0] tgt);
      @(negedge clk);
      advance       = 1'b1;
      branch_taken  = bt;
      branch_target = tgt;
      @(negedge clk);
      advance       = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'd0;
   endtask

   typedef struct {
      logic        rst_first;
      logic        bt;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic [31:0] exp_ir;
      logic        exp_valid;
      logic        exp_halted;
      logic        exp_fault;
      logic [1:0]  exp_cause;
      logic [31:0] exp_faddr;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_fetch;
      clk           = 1'b0;
      rst_n         = 1'b0;
      advance       = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'd0;
      respond_en    = 1'b1;

      vecs[0] = '{1'b1, 1'b0, 32'h0,           32'h0100_0004, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 32'h0100_0100, 32'h0100_0100, 32'h00A0_0113, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
      vecs[2] = '{1'b0, 1'b1, 32'h0100_0102, 32'h0100_0100, 32'h00A0_0113, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0100_0102};
      vecs[3] = '{1'b1, 1'b1, 32'h0100_0800, 32'h0100_0000, 32'h0200_0103, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0100_0800};
      vecs[4] = '{1'b1, 1'b0, 32'h0100_0103, 32'h0100_0004, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
      vecs[5] = '{1'b0, 1'b1, 32'h0200_0000, 32'h0100_0004, 32'h0050_0093, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0200_0000};
      vecs[6] = '{1'b1, 1'b1, 32'h0100_0803, 32'h0100_0000, 32'h0200_0103, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0100_0803};
      vecs[7] = '{1'b1, 1'b1, 32'h0100_07F8, 32'h0100_07F8, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
      vecs[8] = '{1'b0, 1'b0, 32'h0,           32'h0100_07FC, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};

      // Reset state, then first fetch: two request cycles before ir_valid.
      repeat (2) @(negedge clk);
      chk("rst_instrfetch", {31'd0, instrfetch}, 32'd0);
      chk("rst_pc", pc, 32'h0100_0000);
      chk("rst_ir", ir, 32'd0);
      chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_fault", {29'd0, fault, fault_cause}, 32'd0);
      rst_n   = 1'b1;
      n_fetch = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ir_valid) break;
         if (instrfetch) n_fetch++;
      end
      chk("first_fetch_cycles", n_fetch, 32'd2);
      chk("first_ir", ir, 32'h0200_0103);
      chk("first_pc", pc, 32'h0100_0000);
      chk("first_valid", {31'd0, ir_valid}, 32'd1);
      chk("issue_instrfetch", {31'd0, instrfetch}, 32'd0);

      for (int v = 0; v < 9; v++) begin
         if (vecs[v].rst_first) begin
            do_reset();
            wait_settle();
         end
         apply_advance(vecs[v].bt, vecs[v].tgt);
         wait_settle();
         chk($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
         chk($sformatf("v%0d_ir", v), ir, vecs[v].exp_ir);
         chk($sformatf("v%0d_valid", v), {31'd0, ir_valid}, {31'd0, vecs[v].exp_valid});
         chk($sformatf("v%0d_halted", v), {31'd0, halted}, {31'd0, vecs[v].exp_halted});
         chk($sformatf("v%0d_fault", v), {31'd0, fault}, {31'd0, vecs[v].exp_fault});
         chk($sformatf("v%0d_cause", v), {30'd0, fault_cause}, {30'd0, vecs[v].exp_cause});
         chk($sformatf("v%0d_faddr", v), fault_addr, vecs[v].exp_faddr);
      end

      // Halted: advance is ignored and nothing is requested.
      apply_advance(1'b1, 32'h0100_0000);
      apply_advance(1'b0, 32'h0);
      chk("halt_pc", pc, 32'h0100_07FC);
      chk("halt_sticky", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, ir_valid}, 32'd0);
      chk("halt_instrfetch", {31'd0, instrfetch}, 32'd0);
      chk("halt_ir", ir, 32'hFFFF_FFFF);

      // Asynchronous reset while a response is in flight.
      do_reset();
      wait_settle();
      @(negedge clk);
      advance = 1'b1;
      @(posedge clk);
      #1 advance = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_instrfetch", {31'd0, instrfetch}, 32'd0);
      chk("arst_pc", pc, 32'h0100_0000);
      chk("arst_ir", ir, 32'd0);
      chk("arst_valid", {31'd0, ir_valid}, 32'd0);
      chk("arst_status", {28'd0, halted, fault, fault_cause}, 32'd0);
      chk("arst_faddr", fault_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_settle();
      chk("restart_pc", pc, 32'h0100_0000);
      chk("restart_ir", ir, 32'h0200_0103);

      // IMEM never answers: fault after eight WAIT cycles.
      respond_en = 1'b0;
      do_reset();
      n_fetch = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fault) break;
         if (instrfetch) n_fetch++;
      end
      chk("to_fetch_cycles", n_fetch, 32'd9);
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_cause", {30'd0, fault_cause}, 32'd3);
      chk("to_faddr", fault_addr, 32'h0100_0000);
      chk("to_instrfetch", {31'd0, instrfetch}, 32'd0);
      respond_en = 1'b1;
      apply_advance(1'b0, 32'h0);
      chk("to_pc_held", pc, 32'h0100_0000);
      chk("to_valid", {31'd0, ir_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
